// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 raster constants, RGB332-to-444 expansion and the
//               VGA_TEST_PATTERN_EN vertical-bar colour function.
// Revision    : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF    = 640;
    localparam int H_FRONT_DEF      = 16;
    localparam int H_SYNC_DEF       = 96;
    localparam int H_BACK_DEF       = 48;
    localparam int V_VISIBLE_DEF    = 480;
    localparam int V_FRONT_DEF      = 10;
    localparam int V_SYNC_DEF       = 2;
    localparam int V_BACK_DEF       = 33;

    localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t RGB_BLACK = '0;

    // MSB replication keeps full-scale inputs at full scale (7 -> F, 3 -> F).
    function automatic rgb444_t rgb332_to_444(input logic [7:0] d);
        rgb444_t c;
        c.r = {d[7:5], d[7]};
        c.g = {d[4:2], d[4]};
        c.b = {d[1:0], d[1:0]};
        return c;
    endfunction

    function automatic rgb444_t bar_color(input logic [2:0] k);
        rgb444_t c;
        c.r = {4{k[0]}};
        c.g = {4{k[1]}};
        c.b = {4{k[2]}};
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay_line
// Description : Parameterised depth/width shift register with per-bit reset
//               value, used to align raster flags with the pixel pipeline.
// Revision    : 1.0
// ============================================================================
module sync_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {DEPTH{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_driver
// Description : VGA raster counters, sync/blank generation and RGB332 pixel
//               output stage aligned to the scene pipeline latency.
//               Define VGA_TEST_PATTERN_EN to replace screen_data with bars.
// Revision    : 1.0
// ============================================================================
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int PIPE_DLY  = 2
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic [7:0] screen_data,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS       = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE       = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SS       = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE       = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_start_q, frame_start_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    rgb444_t    color_q, color_d;

    logic       w_vis;
    logic       w_hs_n;
    logic       w_vs_n;
    logic [2:0] w_flags_dly;
    rgb444_t    w_pix_color;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
        // Registered from the next count so the pulse coincides with (0,0).
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign w_vis  = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    assign w_hs_n = !((h_cnt_q >= H_SS) && (h_cnt_q <= H_SE));
    assign w_vs_n = !((v_cnt_q >= V_SS) && (v_cnt_q <= V_SE));

    // PIPE_DLY stages here plus the output register give the full latency.
    sync_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL (3'b011)
    ) u_flag_dly (
        .clk  (clk_25m),
        .rst  (rst),
        .din  ({w_vis, w_hs_n, w_vs_n}),
        .dout (w_flags_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar_dly;

    sync_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_bar_dly (
        .clk  (clk_25m),
        .rst  (rst),
        .din  (h_cnt_q[9:7]),
        .dout (w_bar_dly)
    );

    assign w_pix_color = bar_color(w_bar_dly);
`else
    assign w_pix_color = rgb332_to_444(screen_data);
`endif

    always_comb begin
        video_on_d = w_flags_dly[2];
        hsync_d    = w_flags_dly[1];
        vsync_d    = w_flags_dly[0];
        color_d    = w_flags_dly[2] ? w_pix_color : RGB_BLACK;
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            video_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            color_q    <= RGB_BLACK;
        end else begin
            video_on_q <= video_on_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            color_q    <= color_d;
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign frame_start = frame_start_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = color_q.r;
    assign vga_g       = color_q.g;
    assign vga_b       = color_q.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_driver
// Description : Self-checking bench for vga_scan_driver with a cycle-count
//               reference model; vertical timing shortened to keep frames small.
// Revision    : 1.0
// ============================================================================
module tb_vga_scan_driver;

    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SW  = 96;
    localparam int H_BP  = 48;
    localparam int V_VIS = 6;
    localparam int V_FP  = 2;
    localparam int V_SW  = 2;
    localparam int V_BP  = 2;
    localparam int DLY   = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int FRAME = H_TOT * V_TOT;

    logic       clk_25m = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] screen_data = 8'h00;
    logic [9:0] pixel_x, pixel_y;
    logic       frame_start, video_on, hsync, vsync;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [35:0] obs;

    always #20 clk_25m = ~clk_25m;

    vga_scan_driver #(
        .H_VISIBLE (H_VIS), .H_FRONT (H_FP), .H_SYNC (H_SW), .H_BACK (H_BP),
        .V_VISIBLE (V_VIS), .V_FRONT (V_FP), .V_SYNC (V_SW), .V_BACK (V_BP),
        .PIPE_DLY  (DLY)
    ) dut (
        .clk_25m     (clk_25m),
        .rst         (rst),
        .screen_data (screen_data),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    assign obs = {pixel_x, pixel_y, hsync, vsync, video_on, vga_r, vga_g, vga_b, frame_start};

    int         n;           // clocks since reset release
    int         n_cmp = 0;
    int         n_fail = 0;
    int         scene_mode = 0;
    logic [7:0] last_byte = 8'h00;

    localparam logic [35:0] RESET_OBS = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};

    function automatic int ex_x(input int m);
        return m % H_TOT;
    endfunction

    function automatic int ex_y(input int m);
        return (m / H_TOT) % V_TOT;
    endfunction

    // Expected outputs in cycle c; b is the scene byte presented in cycle c-1.
    function automatic logic [35:0] exp_out(input int c, input logic [7:0] b);
        int         m;
        logic       vis, hs, vs, fs;
        logic [3:0] r, g, bl;
        logic [2:0] k;
        m   = c - (DLY + 1);
        vis = 1'b0; hs = 1'b1; vs = 1'b1;
        r = 4'h0; g = 4'h0; bl = 4'h0;
        if (m >= 0) begin
            vis = (ex_x(m) < H_VIS) && (ex_y(m) < V_VIS);
            hs  = !((ex_x(m) >= H_VIS + H_FP) && (ex_x(m) < H_VIS + H_FP + H_SW));
            vs  = !((ex_y(m) >= V_VIS + V_FP) && (ex_y(m) < V_VIS + V_FP + V_SW));
        end
        if (vis) begin
`ifdef VGA_TEST_PATTERN_EN
            k  = 3'(ex_x(m) / 128);
            r  = k[0] ? 4'hF : 4'h0;
            g  = k[1] ? 4'hF : 4'h0;
            bl = k[2] ? 4'hF : 4'h0;
`else
            k  = 3'd0;
            r  = {b[7:5], b[7]};
            g  = {b[4:2], b[4]};
            bl = {b[1:0], b[1:0]};
`endif
        end
        fs = (c > 0) && (ex_x(c) == 0) && (ex_y(c) == 0);
        return {10'(ex_x(c)), 10'(ex_y(c)), hs, vs, vis, r, g, bl, fs};
    endfunction

    // Present the scene byte for the coordinates issued DLY clocks ago, then advance.
    task automatic step();
        logic [7:0] b;
        int         m;
        m = n - DLY;
        if (scene_mode == 1) b = (m >= 0 && ex_x(m) < 320) ? 8'hE0 : 8'h1F;
        else                 b = 8'($urandom);
        screen_data = b;
        last_byte   = b;
        @(posedge clk_25m);
        @(negedge clk_25m);
        n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_25m);
        @(negedge clk_25m);
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", obs, RESET_OBS);
        end
        rst = 1'b0;
        n   = 0;
        n_cmp++;
        if (obs !== exp_out(n, last_byte)) begin
            n_fail++;
            $display("FAIL release_state got=%h exp=%h", obs, exp_out(n, last_byte));
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (pixel_x !== 10'(n) || pixel_y !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_count n=%0d got x=%0d y=%0d exp x=%0d y=0", n, pixel_x, pixel_y, n);
            end
        end
    endtask

    task automatic test_line_timing();
        logic [9:0] px_hist [DLY+2];
        logic       prev_hs;
        logic       in_pulse;
        int         low_len, falls [$];
        prev_hs = hsync; in_pulse = 1'b0; low_len = 0;
        for (int j = 0; j < DLY + 2; j++) px_hist[j] = 10'h3FF;
        scene_mode = 0;
        for (int i = 0; i < 2 * H_TOT + 100; i++) begin
            step();
            for (int j = DLY + 1; j > 0; j--) px_hist[j] = px_hist[j-1];
            px_hist[0] = pixel_x;
            n_cmp++;
            if (obs !== exp_out(n, last_byte)) begin
                n_fail++;
                $display("FAIL line_outputs n=%0d got=%h exp=%h", n, obs, exp_out(n, last_byte));
            end
            if (prev_hs && !hsync) begin
                falls.push_back(n);
                in_pulse = 1'b1;
                low_len  = 0;
                n_cmp++;
                if (px_hist[DLY+1] !== 10'd656) begin
                    n_fail++;
                    $display("FAIL hsync_start n=%0d got pixel_x=%0d %0d clocks earlier exp=656", n, px_hist[DLY+1], DLY + 1);
                end
            end
            if (!hsync) low_len++;
            if (in_pulse && !prev_hs && hsync) begin
                in_pulse = 1'b0;
                n_cmp++;
                if (low_len != H_SW) begin
                    n_fail++;
                    $display("FAIL hsync_width got=%0d exp=%0d", low_len, H_SW);
                end
            end
            prev_hs = hsync;
        end
        n_cmp++;
        if (falls.size() < 2) begin
            n_fail++;
            $display("FAIL hsync_pulses got=%0d exp>=2", falls.size());
        end else begin
            n_cmp++;
            if (falls[1] - falls[0] != H_TOT) begin
                n_fail++;
                $display("FAIL hsync_period got=%0d exp=%0d", falls[1] - falls[0], H_TOT);
            end
        end
    endtask

    task automatic test_frame_timing();
        int pulses, first, period, vs_low;
        pulses = 0; first = 0; period = 0; vs_low = 0;
        scene_mode = 0;
        for (int i = 0; i < 3 * FRAME && pulses < 2; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_out(n, last_byte)) begin
                n_fail++;
                $display("FAIL frame_outputs n=%0d got=%h exp=%h", n, obs, exp_out(n, last_byte));
            end
            if (frame_start) begin
                pulses++;
                if (pulses == 1) first = n;
                else period = n - first;
            end
            if (pulses == 1 && !vsync) vs_low++;
        end
        n_cmp++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL frame_pulses got=%0d exp=2 (cycle budget expired)", pulses);
        end else begin
            n_cmp++;
            if (period != FRAME) begin
                n_fail++;
                $display("FAIL frame_period got=%0d exp=%0d", period, FRAME);
            end
            n_cmp++;
            if (vs_low != V_SW * H_TOT) begin
                n_fail++;
                $display("FAIL vsync_low_clocks got=%0d exp=%0d", vs_low, V_SW * H_TOT);
            end
        end
    endtask

    task automatic test_colour_mapping();
        logic        seen0, seen320;
        logic [11:0] exp0, exp320;
        int          m;
`ifdef VGA_TEST_PATTERN_EN
        exp0 = 12'h000; exp320 = 12'h0F0;
`else
        exp0 = 12'hF00; exp320 = 12'h0FF;
`endif
        seen0 = 1'b0; seen320 = 1'b0;
        scene_mode = 1;
        for (int i = 0; i < FRAME + 2 * H_TOT && !(seen0 && seen320); i++) begin
            step();
            m = n - (DLY + 1);
            n_cmp++;
            if (obs !== exp_out(n, last_byte)) begin
                n_fail++;
                $display("FAIL colour_outputs n=%0d got=%h exp=%h", n, obs, exp_out(n, last_byte));
            end
            if (!video_on) begin
                n_cmp++;
                if ({vga_r, vga_g, vga_b} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL blank_colour n=%0d got=%h exp=000", n, {vga_r, vga_g, vga_b});
                end
            end
            if (ex_y(m) < V_VIS && ex_x(m) == 0) begin
                seen0 = 1'b1;
                n_cmp++;
                if ({video_on, vga_r, vga_g, vga_b} !== {1'b1, exp0}) begin
                    n_fail++;
                    $display("FAIL colour_x0 got=%h exp=%h", {video_on, vga_r, vga_g, vga_b}, {1'b1, exp0});
                end
            end
            if (ex_y(m) < V_VIS && ex_x(m) == 320) begin
                seen320 = 1'b1;
                n_cmp++;
                if ({video_on, vga_r, vga_g, vga_b} !== {1'b1, exp320}) begin
                    n_fail++;
                    $display("FAIL colour_x320 got=%h exp=%h", {video_on, vga_r, vga_g, vga_b}, {1'b1, exp320});
                end
            end
        end
        n_cmp++;
        if (!(seen0 && seen320)) begin
            n_fail++;
            $display("FAIL colour_coverage got seen0=%0b seen320=%0b exp 1 1", seen0, seen320);
        end
        scene_mode = 0;
    endtask

    task automatic test_reset_mid_frame();
        logic found;
        found = 1'b0;
        for (int i = 0; i < FRAME + H_TOT && !found; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_out(n, last_byte)) begin
                n_fail++;
                $display("FAIL prereset_outputs n=%0d got=%h exp=%h", n, obs, exp_out(n, last_byte));
            end
            found = (ex_x(n) == 400) && (ex_y(n) == 3);
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_400_3 got=not reached exp=reached");
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", obs, RESET_OBS);
        end
        repeat (2) @(posedge clk_25m);
        @(negedge clk_25m);
        rst = 1'b0;
        n   = 0;
        n_cmp++;
        if (obs !== exp_out(n, last_byte)) begin
            n_fail++;
            $display("FAIL post_release got=%h exp=%h", obs, exp_out(n, last_byte));
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_out(n, last_byte)) begin
                n_fail++;
                $display("FAIL restart_outputs n=%0d got=%h exp=%h", n, obs, exp_out(n, last_byte));
            end
        end
    endtask

    initial begin
        n = 0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_colour_mapping();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
